// File: rtl/uart_ascii_rx.sv
// 8N1 UART receiver with mid-bit sampling for the text display path.
// A good frame updates ascii with a one-cycle ascii_ready strobe; a bad stop bit pulses frame_err.
//
// state   | meaning
// S_IDLE  | line idle, waiting for the first low rx_s
// S_START | timing to the start-bit centre to confirm it is still low
// S_DATA  | sampling eight data bits LSB first at bit centres
// S_STOP  | sampling the stop bit at its centre
// S_BREAK | stop bit was low; waiting for the line to return high
module uart_ascii_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] ascii,
  output logic       ascii_ready,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic [7:0]    ascii_n;
  logic          ready_n;
  logic          err_n;
  logic          sync1;
  logic          rx_s;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      ascii       <= 8'h00;
      ascii_ready <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      sh          <= sh_n;
      ascii       <= ascii_n;
      ascii_ready <= ready_n;
      frame_err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    ascii_n = ascii;
    ready_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          sh_n[idx] = rx_s;
          if (idx == 3'd7) state_n = S_STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            ascii_n = sh;
            ready_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
